wrr_packet_arbiter: RTL and testbench

- Weighted round-robin arbiter sharing one packet datapath among NUM_PORTS requesters.
- Grants are packet-granular. The owner keeps the grant until it has sent up to weight_i[p] packets (each ended by a last beat), then ownership rotates.
- Sits in front of the shared datapath mux. The gnt_o and gnt_id_o outputs drive the mux select; beat_i and last_i come back from the datapath.

---
 rtl/wrr_packet_arbiter.sv | 144 ++++++++++++++
 tb/tb_wrr_packet_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/wrr_packet_arbiter.sv
// Weighted round-robin, packet-granular arbiter for a shared datapath mux.
// Optional idle-owner timeout enabled by defining WRR_ARB_OWNER_TIMEOUT_EN.
module wrr_packet_arbiter #(
  parameter int unsigned NUM_PORTS      = 4,
  parameter int unsigned WEIGHT_W       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PORTS-1:0]           req_i,
  input  logic [NUM_PORTS*WEIGHT_W-1:0]  weight_i,
  input  logic                           beat_i,
  input  logic                           last_i,
  output logic [NUM_PORTS-1:0]           gnt_o,
  output logic [$clog2(NUM_PORTS)-1:0]   gnt_id_o,
  output logic                           busy_o,
  output logic                           timeout_o
);

  localparam int unsigned IdW = $clog2(NUM_PORTS);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e                 state_q, state_d;
  logic [NUM_PORTS-1:0]   gnt_q, gnt_d;
  logic [IdW-1:0]         id_q, id_d;
  logic [IdW-1:0]         ptr_q, ptr_d;
  logic [WEIGHT_W-1:0]    credit_q, credit_d;
  logic                   timeout_q, timeout_d;

  logic [IdW-1:0]         sel, cand;
  logic                   found;
  logic [WEIGHT_W-1:0]    sel_weight;
  logic                   rel;
  logic                   tmo_hit;

  // First requester at or after the priority pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    sel   = ptr_q;
    cand  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = IdW'((32'(ptr_q) + i) % NUM_PORTS);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  assign sel_weight = weight_i[32'(sel)*WEIGHT_W +: WEIGHT_W];

`ifdef WRR_ARB_OWNER_TIMEOUT_EN
  localparam int unsigned       TmoW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0]   TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = (state_q == StGrant) && !beat_i && (tmo_cnt_q == TmoLast);

  // Held at zero while idle so the count starts from zero on every grant.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == StIdle || beat_i) begin
      tmo_cnt_d = '0;
    end else if (!tmo_hit) begin
      tmo_cnt_d = tmo_cnt_q + TmoW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    credit_d  = credit_q;
    timeout_d = 1'b0;
    rel       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d  = StGrant;
          gnt_d    = NUM_PORTS'(1) << sel;
          id_d     = sel;
          credit_d = (sel_weight == '0) ? WEIGHT_W'(1) : sel_weight;
        end
      end
      StGrant: begin
        if (beat_i && last_i) begin
          credit_d = credit_q - WEIGHT_W'(1);
          rel      = (credit_q == WEIGHT_W'(1)) || !req_i[id_q];
        end else if (!beat_i && !req_i[id_q]) begin
          rel = 1'b1;
        end else if (tmo_hit) begin
          rel       = 1'b1;
          timeout_d = 1'b1;
        end
        // gnt_id holds the last owner through idle.
        if (rel) begin
          state_d  = StIdle;
          gnt_d    = '0;
          ptr_d    = IdW'((32'(id_q) + 1) % NUM_PORTS);
          credit_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      id_q      <= '0;
      ptr_q     <= '0;
      credit_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      credit_q  <= credit_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_id_o  = id_q;
  assign busy_o    = (state_q == StGrant);
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_wrr_packet_arbiter.sv
// Vector-table bench for wrr_packet_arbiter; each record is one clock of stimulus
// plus the outputs expected after that edge, routed through a scoreboard queue.
module tb_wrr_packet_arbiter;

  localparam int unsigned NumPorts = 4;
  localparam int unsigned WeightW  = 4;
  localparam int unsigned TmoCyc   = 8;

  typedef struct {
    string       tag;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] w;
    logic        beat;
    logic        last;
    logic [3:0]  e_gnt;
    logic [1:0]  e_id;
    logic        e_busy;
    logic        e_tmo;
  } vec_t;

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       tmo;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_i;
  logic [15:0] weight_i;
  logic        beat_i;
  logic        last_i;
  logic [3:0]  gnt_o;
  logic [1:0]  gnt_id_o;
  logic        busy_o;
  logic        timeout_o;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  wrr_packet_arbiter #(
    .NUM_PORTS     (NumPorts),
    .WEIGHT_W      (WeightW),
    .TIMEOUT_CYCLES(TmoCyc)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_i    (req_i),
    .weight_i (weight_i),
    .beat_i   (beat_i),
    .last_i   (last_i),
    .gnt_o    (gnt_o),
    .gnt_id_o (gnt_id_o),
    .busy_o   (busy_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic add(input string tag, input logic rst, input logic [3:0] req,
                     input logic [15:0] w, input logic beat, input logic last,
                     input logic [3:0] eg, input logic [1:0] eid, input logic eb,
                     input logic et);
    vec_t v;
    v.tag = tag; v.rst = rst; v.req = req; v.w = w; v.beat = beat; v.last = last;
    v.e_gnt = eg; v.e_id = eid; v.e_busy = eb; v.e_tmo = et;
    vecs.push_back(v);
  endtask

  task automatic check_outputs();
    exp_t e;
    if (sb_q.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_empty: no expected entry for sampled outputs");
      return;
    end
    e = sb_q.pop_front();
    checks++;
    if ({gnt_o, gnt_id_o, busy_o, timeout_o} !== {e.gnt, e.id, e.busy, e.tmo}) begin
      errors++;
      $display("FAIL %s: got gnt=%b id=%0d busy=%b tmo=%b, want gnt=%b id=%0d busy=%b tmo=%b",
               e.tag, gnt_o, gnt_id_o, busy_o, timeout_o, e.gnt, e.id, e.busy, e.tmo);
    end
  endtask

  initial begin
    logic [15:0] w1;
    w1 = 16'h1111;
    reset = 1'b1; req_i = '0; weight_i = w1; beat_i = 1'b0; last_i = 1'b0;

    // Reset, idle with no requests, beats ignored in idle.
    add("reset",      1, 4'h0, w1, 0, 0, 4'b0000, 0, 0, 0);
    for (int i = 0; i < 5; i++) add("idle_noreq", 0, 4'h0, w1, 0, 0, 4'b0000, 0, 0, 0);
    add("idle_beat",  0, 4'h0, w1, 1, 1, 4'b0000, 0, 0, 0);

    // Equal weights, all requesting, two-beat packets: 0,1,2,3,0 with a gap.
    for (int p = 0; p < 4; p++) begin
      add("rr_grant",   0, 4'hF, w1, 0, 0, 4'(1 << p), 2'(p), 1, 0);
      add("rr_midbeat", 0, 4'hF, w1, 1, 0, 4'(1 << p), 2'(p), 1, 0);
      add("rr_release", 0, 4'hF, w1, 1, 1, 4'b0000,    2'(p), 0, 0);
    end
    add("rr_wrap_grant",   0, 4'hF, w1, 0, 0, 4'b0001, 0, 1, 0);
    add("rr_wrap_release", 0, 4'hF, w1, 1, 1, 4'b0000, 0, 0, 0);

    // Port 1 weight 3: three back-to-back packets, then port 2, then port 1.
    add("wt_reset",   1, 4'h0, 16'h1131, 0, 0, 4'b0000, 0, 0, 0);
    add("wt_grant1",  0, 4'h6, 16'h1131, 0, 0, 4'b0010, 1, 1, 0);
    add("wt_pkt1",    0, 4'h6, 16'h1131, 1, 1, 4'b0010, 1, 1, 0);
    add("wt_pkt2_wchg", 0, 4'h6, 16'h1111, 1, 1, 4'b0010, 1, 1, 0);
    add("wt_pkt3",    0, 4'h6, 16'h1131, 1, 1, 4'b0000, 1, 0, 0);
    add("wt_grant2",  0, 4'h6, 16'h1131, 0, 0, 4'b0100, 2, 1, 0);
    add("wt_pkt_p2",  0, 4'h6, 16'h1131, 1, 1, 4'b0000, 2, 0, 0);
    add("wt_regrant1", 0, 4'h6, 16'h1131, 0, 0, 4'b0010, 1, 1, 0);
    add("wt_hold",    0, 4'h6, 16'h1131, 1, 1, 4'b0010, 1, 1, 0);

    // Owner 2 aborts; pointer moves to 3 and wraps to pending port 0.
    add("ab_reset",   1, 4'h0, w1, 0, 0, 4'b0000, 0, 0, 0);
    add("ab_grant2",  0, 4'h4, w1, 0, 0, 4'b0100, 2, 1, 0);
    add("ab_nopreempt", 0, 4'h5, w1, 0, 0, 4'b0100, 2, 1, 0);
    add("ab_drop",    0, 4'h1, w1, 0, 0, 4'b0000, 2, 0, 0);
    add("ab_wrap0",   0, 4'h1, w1, 0, 0, 4'b0001, 0, 1, 0);
    add("ab_release", 0, 4'h1, w1, 1, 1, 4'b0000, 0, 0, 0);

    // Weight 0 on port 3 behaves as 1; idle beats do nothing; ptr wraps to 0.
    add("w0_reset",   1, 4'h0, 16'h0111, 0, 0, 4'b0000, 0, 0, 0);
    add("w0_grant3",  0, 4'h8, 16'h0111, 0, 0, 4'b1000, 3, 1, 0);
    add("w0_release", 0, 4'h8, 16'h0111, 1, 1, 4'b0000, 3, 0, 0);
    add("w0_idlebeat1", 0, 4'h0, 16'h0111, 1, 1, 4'b0000, 3, 0, 0);
    add("w0_idlebeat2", 0, 4'h0, 16'h0111, 1, 0, 4'b0000, 3, 0, 0);
    add("w0_ptrwrap", 0, 4'h1, 16'h0111, 0, 0, 4'b0001, 0, 1, 0);

    // Reset mid-grant drops the owner and restores ptr=0.
    add("mr_release", 0, 4'h1, w1, 1, 1, 4'b0000, 0, 0, 0);
    add("mr_grant1",  0, 4'hF, w1, 0, 0, 4'b0010, 1, 1, 0);
    add("mr_reset",   1, 4'hF, w1, 1, 0, 4'b0000, 0, 0, 0);
    add("mr_ptr0",    0, 4'hF, w1, 0, 0, 4'b0001, 0, 1, 0);

    // Stalled owner.
    add("to_reset",   1, 4'h0, w1, 0, 0, 4'b0000, 0, 0, 0);
    add("to_grant",   0, 4'h1, w1, 0, 0, 4'b0001, 0, 1, 0);
`ifdef WRR_ARB_OWNER_TIMEOUT_EN
    for (int i = 0; i < 3; i++) add("to_stall", 0, 4'h1, w1, 0, 0, 4'b0001, 0, 1, 0);
    add("to_beat", 0, 4'h1, w1, 1, 0, 4'b0001, 0, 1, 0);
    for (int i = 0; i < 7; i++) add("to_hold", 0, 4'h1, w1, 0, 0, 4'b0001, 0, 1, 0);
    add("to_fire",    0, 4'h1, w1, 0, 0, 4'b0000, 0, 0, 1);
    add("to_pulse_end", 0, 4'h0, w1, 0, 0, 4'b0000, 0, 0, 0);
    add("to_regrant", 0, 4'h2, w1, 0, 0, 4'b0010, 1, 1, 0);
    for (int i = 0; i < 7; i++) add("to_hold2", 0, 4'h2, w1, 0, 0, 4'b0010, 1, 1, 0);
    add("to_fire2",   0, 4'h2, w1, 0, 0, 4'b0000, 1, 0, 1);
`else
    for (int i = 0; i < 20; i++) add("to_held", 0, 4'h1, w1, 0, 0, 4'b0001, 0, 1, 0);
    add("to_release", 0, 4'h1, w1, 1, 1, 4'b0000, 0, 0, 0);
`endif

    foreach (vecs[k]) begin
      exp_t e;
      @(negedge clk);
      reset    = vecs[k].rst;
      req_i    = vecs[k].req;
      weight_i = vecs[k].w;
      beat_i   = vecs[k].beat;
      last_i   = vecs[k].last;
      e.tag = vecs[k].tag; e.gnt = vecs[k].e_gnt; e.id = vecs[k].e_id;
      e.busy = vecs[k].e_busy; e.tmo = vecs[k].e_tmo;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      check_outputs();
    end

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // One-hot-or-zero grant, checked every cycle once out of reset.
  always @(negedge clk) begin
    if (reset === 1'b0 && !$isunknown(gnt_o) && !$onehot0(gnt_o)) begin
      errors++;
      checks++;
      $display("FAIL gnt_onehot: got gnt=%b, want one-hot or zero", gnt_o);
    end
  end

endmodule
